// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard controller: FSM states and forwarding-select codes.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_MWAIT = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

endpackage

// File: rtl/fwd_sel.sv
// Single-operand forwarding select (EX > MEM > WB) plus the EX-load match used for load-use stalls.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] src,
  input  logic             use_src,
  input  logic [REG_W-1:0] rd_ex,
  input  logic [REG_W-1:0] rd_mem,
  input  logic [REG_W-1:0] rd_wb,
  input  logic             rf_le_ex,
  input  logic             rf_le_mem,
  input  logic             rf_le_wb,
  input  logic             l_ex,
  output logic [1:0]       fwd,
  output logic             load_hit
);

  logic hit_ex, hit_mem, hit_wb;

  // R0 is hard-wired zero, so it never matches a producer.
  assign hit_ex  = use_src && rf_le_ex  && (rd_ex  != '0) && (rd_ex  == src);
  assign hit_mem = use_src && rf_le_mem && (rd_mem != '0) && (rd_mem == src);
  assign hit_wb  = use_src && rf_le_wb  && (rd_wb  != '0) && (rd_wb  == src);

  assign load_hit = hit_ex && l_ex;

  always_comb begin
    fwd = FWD_RF;
    if (hit_ex && !l_ex) fwd = FWD_EX;
    else if (hit_mem)    fwd = FWD_MEM;
    else if (hit_wb)     fwd = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, redirect flushes, memory-wait freeze, operand forwarding.
// Optional HAZARD_PERF_EN adds saturating stall/flush/wait performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W        = 5,
  parameter int FLUSH_CYCLES = 1
`ifdef HAZARD_PERF_EN
  ,
  parameter int CNT_W        = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] ra_id,
  input  logic [REG_W-1:0] rb_id,
  input  logic [REG_W-1:0] rd_id,
  input  logic             a_s_id,
  input  logic             b_s_id,
  input  logic             d_s_id,
  input  logic [REG_W-1:0] rd_ex,
  input  logic [REG_W-1:0] rd_mem,
  input  logic [REG_W-1:0] rd_wb,
  input  logic             rf_le_ex,
  input  logic             rf_le_mem,
  input  logic             rf_le_wb,
  input  logic             l_ex,
  input  logic             redirect_ex,
  input  logic             mem_busy,
  output logic             pc_le,
  output logic             if_id_le,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       fwd_d,
`ifdef HAZARD_PERF_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt,
`endif
  output logic [1:0]       state_o
);

  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  state_t     state, state_d, ret, ret_d, eff;
  logic [2:0] cnt, cnt_d;
  logic [1:0] fa, fb, fd;
  logic       lh_a, lh_b, lh_d, load_use;

  fwd_sel #(.REG_W(REG_W)) u_fwd_a (
    .src(ra_id), .use_src(a_s_id), .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
    .rf_le_ex(rf_le_ex), .rf_le_mem(rf_le_mem), .rf_le_wb(rf_le_wb), .l_ex(l_ex),
    .fwd(fa), .load_hit(lh_a)
  );
  fwd_sel #(.REG_W(REG_W)) u_fwd_b (
    .src(rb_id), .use_src(b_s_id), .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
    .rf_le_ex(rf_le_ex), .rf_le_mem(rf_le_mem), .rf_le_wb(rf_le_wb), .l_ex(l_ex),
    .fwd(fb), .load_hit(lh_b)
  );
  fwd_sel #(.REG_W(REG_W)) u_fwd_d (
    .src(rd_id), .use_src(d_s_id), .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
    .rf_le_ex(rf_le_ex), .rf_le_mem(rf_le_mem), .rf_le_wb(rf_le_wb), .l_ex(l_ex),
    .fwd(fd), .load_hit(lh_d)
  );

  assign load_use = lh_a || lh_b || lh_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_RUN;
      ret   <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_d;
      ret   <= ret_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    pc_le       = 1'b1;
    if_id_le    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    state_d     = state;
    ret_d       = ret;
    cnt_d       = cnt;
    // On the MWAIT exit cycle the saved state's rules apply, so a held redirect acts immediately.
    eff         = (state == ST_MWAIT) ? ret : state;
    if (mem_busy) begin
      pc_le    = 1'b0;
      if_id_le = 1'b0;
      state_d  = ST_MWAIT;
      if (state != ST_MWAIT) ret_d = state;
    end else begin
      case (eff)
        ST_FLUSH: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          cnt_d       = cnt - 3'd1;
          state_d     = (cnt <= 3'd1) ? ST_RUN : ST_FLUSH;
        end
        default: begin
          state_d = ST_RUN;
          if (redirect_ex) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d = ST_FLUSH;
              cnt_d   = CNT_INIT;
            end
          end else if (load_use) begin
            pc_le       = 1'b0;
            if_id_le    = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
      endcase
    end
    if (!reset) begin
      pc_le       = 1'b0;
      if_id_le    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  assign fwd_a   = reset ? fa : FWD_RF;
  assign fwd_b   = reset ? fb : FWD_RF;
  assign fwd_d   = reset ? fd : FWD_RF;
  assign state_o = state;

`ifdef HAZARD_PERF_EN
  logic stall_ev, flush_ev, wait_ev;

  // Only a load-use stall bubbles ID/EX while leaving IF/ID unflushed.
  assign stall_ev = id_ex_flush && !if_id_flush;
  assign flush_ev = if_id_flush || id_ex_flush;
  assign wait_ev  = (state == ST_MWAIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      if (stall_ev && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (flush_ev && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
      if (wait_ev  && wait_cnt  != '1) wait_cnt  <= wait_cnt  + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with FLUSH_CYCLES=3.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ra_id, rb_id, rd_id, rd_ex, rd_mem, rd_wb;
  logic       a_s_id, b_s_id, d_s_id, rf_le_ex, rf_le_mem, rf_le_wb;
  logic       l_ex, redirect_ex, mem_busy;
  logic       pc_le, if_id_le, if_id_flush, id_ex_flush;
  logic [1:0] fwd_a, fwd_b, fwd_d, state_o;
  logic [3:0] ctl;
`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt, flush_cnt, wait_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign ctl = {pc_le, if_id_le, if_id_flush, id_ex_flush};

  hazard_ctrl #(.REG_W(5), .FLUSH_CYCLES(3)) dut (
    .clk(clk), .reset(reset),
    .ra_id(ra_id), .rb_id(rb_id), .rd_id(rd_id),
    .a_s_id(a_s_id), .b_s_id(b_s_id), .d_s_id(d_s_id),
    .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
    .rf_le_ex(rf_le_ex), .rf_le_mem(rf_le_mem), .rf_le_wb(rf_le_wb),
    .l_ex(l_ex), .redirect_ex(redirect_ex), .mem_busy(mem_busy),
    .pc_le(pc_le), .if_id_le(if_id_le), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_d(fwd_d),
`ifdef HAZARD_PERF_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt),
`endif
    .state_o(state_o)
  );

  task automatic idle();
    ra_id = '0; rb_id = '0; rd_id = '0; a_s_id = 0; b_s_id = 0; d_s_id = 0;
    rd_ex = '0; rd_mem = '0; rd_wb = '0; rf_le_ex = 0; rf_le_mem = 0; rf_le_wb = 0;
    l_ex = 0; redirect_ex = 0; mem_busy = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    ra_id = 5'd3; a_s_id = 1; rd_ex = 5'd3; rf_le_ex = 1;
    #2;
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", state_o); end
    total++; if (ctl !== 4'b0011) begin bad++; $display("FAIL rst_ctl got=%b want=0011", ctl); end
    total++; if (fwd_a !== 2'd0) begin bad++; $display("FAIL rst_fwd_a got=%0d want=0", fwd_a); end
`ifdef HAZARD_PERF_EN
    total++; if ({stall_cnt, flush_cnt, wait_cnt} !== '0) begin bad++; $display("FAIL rst_perf got=%0d/%0d/%0d want=0", stall_cnt, flush_cnt, wait_cnt); end
`endif
    tick();
    reset = 1'b1;
    idle();
    #1;
    total++; if (ctl !== 4'b1100) begin bad++; $display("FAIL run_ctl got=%b want=1100", ctl); end
  endtask

  task automatic test_forward();
    idle();
    ra_id = 5'd3; a_s_id = 1; rd_ex = 5'd3; rf_le_ex = 1;
    #1;
    total++; if (fwd_a !== 2'd1) begin bad++; $display("FAIL fwd_ex got=%0d want=1", fwd_a); end
    total++; if (ctl !== 4'b1100) begin bad++; $display("FAIL fwd_ex_ctl got=%b want=1100", ctl); end
    total++; if (fwd_b !== 2'd0) begin bad++; $display("FAIL fwd_b_idle got=%0d want=0", fwd_b); end
    idle();
    ra_id = 5'd0; a_s_id = 1; rd_ex = 5'd0; rf_le_ex = 1; l_ex = 1;
    #1;
    total++; if (fwd_a !== 2'd0) begin bad++; $display("FAIL r0_fwd got=%0d want=0", fwd_a); end
    total++; if (ctl !== 4'b1100) begin bad++; $display("FAIL r0_ctl got=%b want=1100", ctl); end
    idle();
    ra_id = 5'd5; rb_id = 5'd5; rd_id = 5'd5; a_s_id = 1; b_s_id = 1; d_s_id = 1;
    rd_ex = 5'd5; rd_mem = 5'd5; rd_wb = 5'd5; rf_le_ex = 1; rf_le_mem = 1; rf_le_wb = 1;
    #1;
    total++; if ({fwd_a, fwd_b, fwd_d} !== 6'b01_01_01) begin bad++; $display("FAIL prio_ex got=%b want=010101", {fwd_a, fwd_b, fwd_d}); end
    rf_le_ex = 0;
    #1;
    total++; if (fwd_a !== 2'd2) begin bad++; $display("FAIL prio_mem got=%0d want=2", fwd_a); end
    rf_le_mem = 0; b_s_id = 0;
    #1;
    total++; if ({fwd_a, fwd_b, fwd_d} !== 6'b11_00_11) begin bad++; $display("FAIL prio_wb got=%b want=110011", {fwd_a, fwd_b, fwd_d}); end
    tick();
  endtask

  task automatic test_load_use();
    idle();
    ra_id = 5'd3; a_s_id = 1; rd_ex = 5'd3; rf_le_ex = 1; l_ex = 1;
    #1;
    total++; if (ctl !== 4'b0001) begin bad++; $display("FAIL lu_ctl got=%b want=0001", ctl); end
    total++; if (fwd_a !== 2'd0) begin bad++; $display("FAIL lu_noex got=%0d want=0", fwd_a); end
    tick();
    idle();
    ra_id = 5'd3; a_s_id = 1; rd_mem = 5'd3; rf_le_mem = 1;
    #1;
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL lu_state got=%0d want=0", state_o); end
    total++; if (fwd_a !== 2'd2) begin bad++; $display("FAIL lu_mem got=%0d want=2", fwd_a); end
    total++; if (ctl !== 4'b1100) begin bad++; $display("FAIL lu_after got=%b want=1100", ctl); end
    idle();
    rd_id = 5'd7; d_s_id = 1; rd_ex = 5'd7; rf_le_ex = 1; l_ex = 1;
    #1;
    total++; if (ctl !== 4'b0001) begin bad++; $display("FAIL lu_d got=%b want=0001", ctl); end
    d_s_id = 0;
    #1;
    total++; if (ctl !== 4'b1100) begin bad++; $display("FAIL lu_unused got=%b want=1100", ctl); end
    tick();
  endtask

  task automatic test_redirect();
    logic [1:0] want_st [4];
    logic [3:0] want_ctl[4];
    want_st  = '{2'd0, 2'd1, 2'd1, 2'd0};
    want_ctl = '{4'b1111, 4'b1111, 4'b1111, 4'b1100};
    idle();
    redirect_ex = 1;
    ra_id = 5'd3; a_s_id = 1; rd_ex = 5'd3; rf_le_ex = 1; l_ex = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (state_o !== want_st[i]) begin bad++; $display("FAIL redir_state[%0d] got=%0d want=%0d", i, state_o, want_st[i]); end
      total++; if (ctl !== want_ctl[i]) begin bad++; $display("FAIL redir_ctl[%0d] got=%b want=%b", i, ctl, want_ctl[i]); end
      tick();
      redirect_ex = (i == 0);
      if (i >= 1) idle();
    end
  endtask

  task automatic test_mwait();
    idle();
    redirect_ex = 1;
    tick();
    redirect_ex = 0;
    #1;
    total++; if (ctl !== 4'b1111) begin bad++; $display("FAIL mw_flush1 got=%b want=1111", ctl); end
    tick();
    mem_busy = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (ctl !== 4'b0000) begin bad++; $display("FAIL mw_ctl[%0d] got=%b want=0000", i, ctl); end
      total++; if (state_o !== ((i == 0) ? 2'd1 : 2'd2)) begin bad++; $display("FAIL mw_state[%0d] got=%0d", i, state_o); end
      tick();
    end
    mem_busy = 0;
    #1;
    total++; if (ctl !== 4'b1111) begin bad++; $display("FAIL mw_resume got=%b want=1111", ctl); end
    total++; if (state_o !== 2'd2) begin bad++; $display("FAIL mw_exit_state got=%0d want=2", state_o); end
    tick();
    total++; if (state_o !== 2'd0 || ctl !== 4'b1100) begin bad++; $display("FAIL mw_done got=%0d/%b want=0/1100", state_o, ctl); end
  endtask

  task automatic test_mwait_redirect();
    idle();
    mem_busy = 1; redirect_ex = 1;
    #1;
    total++; if (ctl !== 4'b0000) begin bad++; $display("FAIL mwr_prio got=%b want=0000", ctl); end
    tick();
    mem_busy = 0;
    #1;
    total++; if (ctl !== 4'b1111) begin bad++; $display("FAIL mwr_exit got=%b want=1111", ctl); end
    tick();
    redirect_ex = 0;
    #1;
    total++; if (state_o !== 2'd1) begin bad++; $display("FAIL mwr_flush got=%0d want=1", state_o); end
    tick(); tick();
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL mwr_back got=%0d want=0", state_o); end
  endtask

  task automatic test_reset_mid_flush();
    idle();
    redirect_ex = 1;
    tick();
    redirect_ex = 0;
    #1;
    total++; if (state_o !== 2'd1) begin bad++; $display("FAIL rmf_pre got=%0d want=1", state_o); end
    reset = 1'b0;
    #1;
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL rmf_state got=%0d want=0", state_o); end
    total++; if (ctl !== 4'b0011) begin bad++; $display("FAIL rmf_ctl got=%b want=0011", ctl); end
`ifdef HAZARD_PERF_EN
    total++; if ({stall_cnt, flush_cnt, wait_cnt} !== '0) begin bad++; $display("FAIL rmf_perf got=%0d/%0d/%0d want=0", stall_cnt, flush_cnt, wait_cnt); end
`endif
    #2;
    reset = 1'b1;
    #1;
    total++; if (ctl !== 4'b1100) begin bad++; $display("FAIL rmf_after got=%b want=1100", ctl); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_redirect();
    test_mwait();
    test_mwait_redirect();
    test_reset_mid_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
